// File: rtl/ttt_move_sequencer.sv
// Turn sequencer in front of the tic-tac-toe game core: accepts human moves,
// scans the board for the computer reply (win, block, preference) and stops
// issuing moves once the core reports a result.
//
// state       | meaning
// ------------+------------------------------------------------------------
// WAIT_PLAYER | idle, accepting a human move request
// PLAY_P      | one-cycle player strobe to the core
// SETTLE_P    | settle delay after a player move, then read winner
// SCAN_WIN    | look for a line the computer can complete
// SCAN_BLOCK  | look for a line the player could complete
// SCAN_PREF   | take the first free cell in preference order
// PLAY_C      | one-cycle computer strobe to the core
// SETTLE_C    | settle delay after a computer move, then read winner
// DONE        | game finished, only reset leaves
module ttt_move_sequencer #(
   parameter int SETTLE_CYCLES = 2,
   parameter bit COMP_FIRST    = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_valid,
   input  logic [3:0] btn_pos,
   input  logic [1:0] pos1,
   input  logic [1:0] pos2,
   input  logic [1:0] pos3,
   input  logic [1:0] pos4,
   input  logic [1:0] pos5,
   input  logic [1:0] pos6,
   input  logic [1:0] pos7,
   input  logic [1:0] pos8,
   input  logic [1:0] pos9,
   input  logic [1:0] winner,
   output logic [3:0] player,
   output logic       plyr_play,
   output logic [3:0] computer,
   output logic       comp_play,
   output logic       btn_ready,
   output logic       btn_reject,
   output logic       game_over,
   output logic [3:0] move_count
);

   typedef enum logic [3:0] {
      WAIT_PLAYER,
      PLAY_P,
      SETTLE_P,
      SCAN_WIN,
      SCAN_BLOCK,
      SCAN_PREF,
      PLAY_C,
      SETTLE_C,
      DONE
   } state_t;

   localparam state_t     RESET_STATE = COMP_FIRST ? SCAN_WIN : WAIT_PLAYER;
   localparam logic [2:0] SETTLE_LOAD = 3'(SETTLE_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] settle_cnt;
   logic [2:0] line_cnt;
   logic [3:0] pref_cnt;

   logic [17:0] board;
   logic [3:0]  la, lb, lc;
   logic [1:0]  va, vb, vc;
   logic [1:0]  scan_mark;
   logic        line_hit;
   logic [3:0]  line_idx;
   logic [3:0]  pref_idx;
   logic        pref_free;
   logic        req_free;

   logic        accept;
   logic        reject_now;
   logic        count_move;
   logic        set_over;
   logic        load_comp;
   logic [3:0]  comp_sel;

   // Cell k of the packed board; indices past 8 read as occupied.
   function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] i);
      case (i)
         4'd0:    return b[1:0];
         4'd1:    return b[3:2];
         4'd2:    return b[5:4];
         4'd3:    return b[7:6];
         4'd4:    return b[9:8];
         4'd5:    return b[11:10];
         4'd6:    return b[13:12];
         4'd7:    return b[15:14];
         4'd8:    return b[17:16];
         default: return 2'b11;
      endcase
   endfunction

   assign board     = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};
   assign req_free  = (btn_pos <= 4'd8) && (cell_at(board, btn_pos) == 2'b00);
   assign scan_mark = (state == SCAN_BLOCK) ? 2'b01 : 2'b10;
   assign va        = cell_at(board, la);
   assign vb        = cell_at(board, lb);
   assign vc        = cell_at(board, lc);
   assign pref_free = (cell_at(board, pref_idx) == 2'b00);

   // Cell triple of the line currently being scanned: rows, columns, diagonals.
   always_comb begin
      la = 4'd0;
      lb = 4'd1;
      lc = 4'd2;
      case (line_cnt)
         3'd0: begin la = 4'd0; lb = 4'd1; lc = 4'd2; end
         3'd1: begin la = 4'd3; lb = 4'd4; lc = 4'd5; end
         3'd2: begin la = 4'd6; lb = 4'd7; lc = 4'd8; end
         3'd3: begin la = 4'd0; lb = 4'd3; lc = 4'd6; end
         3'd4: begin la = 4'd1; lb = 4'd4; lc = 4'd7; end
         3'd5: begin la = 4'd2; lb = 4'd5; lc = 4'd8; end
         3'd6: begin la = 4'd0; lb = 4'd4; lc = 4'd8; end
         3'd7: begin la = 4'd2; lb = 4'd4; lc = 4'd6; end
         default: ;
      endcase
   end

   // Line hit: two cells carry the scan mark and the third is empty.
   always_comb begin
      line_hit = 1'b0;
      line_idx = 4'd0;
      if (va == scan_mark && vb == scan_mark && vc == 2'b00) begin
         line_hit = 1'b1;
         line_idx = lc;
      end else if (va == scan_mark && vc == scan_mark && vb == 2'b00) begin
         line_hit = 1'b1;
         line_idx = lb;
      end else if (vb == scan_mark && vc == scan_mark && va == 2'b00) begin
         line_hit = 1'b1;
         line_idx = la;
      end
   end

   // Preference order: centre, corners, then edges.
   always_comb begin
      pref_idx = 4'd4;
      case (pref_cnt)
         4'd0:    pref_idx = 4'd4;
         4'd1:    pref_idx = 4'd0;
         4'd2:    pref_idx = 4'd2;
         4'd3:    pref_idx = 4'd6;
         4'd4:    pref_idx = 4'd8;
         4'd5:    pref_idx = 4'd1;
         4'd6:    pref_idx = 4'd3;
         4'd7:    pref_idx = 4'd5;
         4'd8:    pref_idx = 4'd7;
         default: pref_idx = 4'd4;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= RESET_STATE;
      else        state <= state_nxt;
   end

   // Next-state logic, strobes and datapath enables.
   always_comb begin
      state_nxt  = state;
      plyr_play  = 1'b0;
      comp_play  = 1'b0;
      btn_ready  = 1'b0;
      accept     = 1'b0;
      reject_now = 1'b0;
      count_move = 1'b0;
      set_over   = 1'b0;
      load_comp  = 1'b0;
      comp_sel   = line_idx;
      case (state)
         WAIT_PLAYER: begin
            btn_ready = 1'b1;
            if (btn_valid) begin
               if (req_free) begin
                  accept    = 1'b1;
                  state_nxt = PLAY_P;
               end else begin
                  reject_now = 1'b1;
               end
            end
         end
         PLAY_P: begin
            plyr_play  = 1'b1;
            count_move = 1'b1;
            state_nxt  = SETTLE_P;
         end
         SETTLE_P, SETTLE_C: begin
            if (settle_cnt == 3'd0) begin
               if (winner != 2'b11) begin
                  set_over  = 1'b1;
                  state_nxt = DONE;
               end else if (move_count == 4'd9) begin
                  state_nxt = DONE;
               end else if (state == SETTLE_P) begin
                  state_nxt = SCAN_WIN;
               end else begin
                  state_nxt = WAIT_PLAYER;
               end
            end
         end
         SCAN_WIN: begin
            if (line_hit) begin
               load_comp = 1'b1;
               state_nxt = PLAY_C;
            end else if (line_cnt == 3'd7) begin
               state_nxt = SCAN_BLOCK;
            end
         end
         SCAN_BLOCK: begin
            if (line_hit) begin
               load_comp = 1'b1;
               state_nxt = PLAY_C;
            end else if (line_cnt == 3'd7) begin
               state_nxt = SCAN_PREF;
            end
         end
         SCAN_PREF: begin
            if (pref_free) begin
               load_comp = 1'b1;
               comp_sel  = pref_idx;
               state_nxt = PLAY_C;
            end else if (pref_cnt == 4'd8) begin
               // Only reachable with a corrupted board; end the game safely.
               set_over  = 1'b1;
               state_nxt = DONE;
            end
         end
         PLAY_C: begin
            comp_play  = 1'b1;
            count_move = 1'b1;
            state_nxt  = SETTLE_C;
         end
         DONE: ;
         default: state_nxt = WAIT_PLAYER;
      endcase
   end

   // Move latches, counters, reject pulse and sticky game-over flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         player     <= 4'd0;
         computer   <= 4'd0;
         btn_reject <= 1'b0;
         game_over  <= 1'b0;
         move_count <= 4'd0;
         settle_cnt <= SETTLE_LOAD;
         line_cnt   <= 3'd0;
         pref_cnt   <= 4'd0;
      end else begin
         btn_reject <= reject_now;
         if (accept)    player   <= btn_pos;
         if (load_comp) computer <= comp_sel;
         if (set_over)  game_over <= 1'b1;
         if (count_move && move_count < 4'd9) move_count <= move_count + 4'd1;

         if ((state == SETTLE_P || state == SETTLE_C) && settle_cnt != 3'd0)
            settle_cnt <= settle_cnt - 3'd1;
         else
            settle_cnt <= SETTLE_LOAD;

         // Wraps 7 -> 0 so the block scan starts on line 0.
         if ((state == SCAN_WIN || state == SCAN_BLOCK) && !line_hit)
            line_cnt <= line_cnt + 3'd1;
         else
            line_cnt <= 3'd0;

         if (state == SCAN_PREF && !pref_free)
            pref_cnt <= pref_cnt + 4'd1;
         else
            pref_cnt <= 4'd0;
      end
   end

endmodule
